// File: rtl/ram_port_b_arbiter.sv
// Shares RAM port B between the VGA display fetch path and the auxiliary (CPU/loader) side.
// Grants are combinational, RAM pins register one cycle later, read data returns RD_LATENCY after that.
module ram_port_b_arbiter #(
   parameter int ADDR_W       = 17,
   parameter int DATA_W       = 32,
   parameter int RD_LATENCY   = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              blank,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_valid,
   output logic [15:0]       disp_miss_cnt,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   input  logic [3:0]        aux_byteena,
   output logic              aux_gnt,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              aux_valid,
   output logic [ADDR_W-1:0] address_b,
   output logic [DATA_W-1:0] data_b,
   output logic [3:0]        byteena_b,
   output logic              rden_b,
   output logic              wren_b,
   input  logic [DATA_W-1:0] q_b
);

   localparam logic [1:0] OWN_IDLE   = 2'd0;
   localparam logic [1:0] OWN_DISP   = 2'd1;
   localparam logic [1:0] OWN_AUX    = 2'd2;
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   logic [1:0]          owner_q, owner_d;
   logic [7:0]          starve_q, starve_d;
   logic [15:0]         miss_q, miss_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [3:0]          be_q, be_d;
   logic                rden_q, rden_d;
   logic                wren_q, wren_d;
   logic [RD_LATENCY:1] tag_vld_q, tag_vld_d;
   logic [RD_LATENCY:1] tag_aux_q, tag_aux_d;
   logic [DATA_W-1:0]   disp_hold_q, disp_hold_d;
   logic [DATA_W-1:0]   aux_hold_q, aux_hold_d;
   logic                force_aux;

   always_comb begin
      force_aux = aux_req && (starve_q == STARVE_MAX);
      owner_d   = OWN_IDLE;
      if (!rst) begin
         if (force_aux || (blank && aux_req)) owner_d = OWN_AUX;
         else if (disp_req)                   owner_d = OWN_DISP;
         else if (aux_req)                    owner_d = OWN_AUX;
      end
      disp_gnt = (owner_d == OWN_DISP);
      aux_gnt  = (owner_d == OWN_AUX);

      addr_d = addr_q;
      data_d = data_q;
      be_d   = be_q;
      rden_d = 1'b0;
      wren_d = 1'b0;
      case (owner_d)
         OWN_DISP: begin
            addr_d = disp_addr;
            be_d   = 4'b1111;
            rden_d = 1'b1;
         end
         OWN_AUX: begin
            addr_d = aux_addr;
            if (aux_we) begin
               data_d = aux_wdata;
               be_d   = aux_byteena;
               wren_d = 1'b1;
            end else begin
               be_d   = 4'b1111;
               rden_d = 1'b1;
            end
         end
         default: ;
      endcase

      starve_d = 8'd0;
      if (aux_req && !aux_gnt)
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 8'd1;
      miss_d = miss_q;
      if (disp_req && !disp_gnt && (miss_q != 16'hFFFF))
         miss_d = miss_q + 16'd1;

      // Stage 0 of the tag pipe is {rden_q, owner_q}; the stages below carry it to q_b time.
      tag_vld_d    = tag_vld_q;
      tag_aux_d    = tag_aux_q;
      tag_vld_d[1] = rden_q;
      tag_aux_d[1] = (owner_q == OWN_AUX);
      for (int k = 2; k <= RD_LATENCY; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_aux_d[k] = tag_aux_q[k-1];
      end

      disp_valid  = !rst && tag_vld_q[RD_LATENCY] && !tag_aux_q[RD_LATENCY];
      aux_valid   = !rst && tag_vld_q[RD_LATENCY] &&  tag_aux_q[RD_LATENCY];
      disp_hold_d = disp_valid ? q_b : disp_hold_q;
      aux_hold_d  = aux_valid  ? q_b : aux_hold_q;
      disp_rdata  = disp_hold_d;
      aux_rdata   = aux_hold_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q     <= OWN_IDLE;
         starve_q    <= 8'd0;
         miss_q      <= 16'd0;
         addr_q      <= '0;
         data_q      <= '0;
         be_q        <= 4'b0000;
         rden_q      <= 1'b0;
         wren_q      <= 1'b0;
         tag_vld_q   <= '0;
         tag_aux_q   <= '0;
         disp_hold_q <= '0;
         aux_hold_q  <= '0;
      end else begin
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         miss_q      <= miss_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         be_q        <= be_d;
         rden_q      <= rden_d;
         wren_q      <= wren_d;
         tag_vld_q   <= tag_vld_d;
         tag_aux_q   <= tag_aux_d;
         disp_hold_q <= disp_hold_d;
         aux_hold_q  <= aux_hold_d;
      end
   end

   assign disp_miss_cnt = miss_q;
   assign address_b     = addr_q;
   assign data_b        = data_q;
   assign byteena_b     = be_q;
   assign rden_b        = rden_q;
   assign wren_b        = wren_q;

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// Bench for ram_port_b_arbiter: RAM model on port B, cycle-level reference model of the
// arbitration rules, directed corner-case sequences and a randomized run.
module tb_ram_port_b_arbiter;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 2;
   localparam int LIMIT  = 8;

   logic              clk = 1'b0;
   logic              rst, blank, disp_req, aux_req, aux_we;
   logic [ADDR_W-1:0] disp_addr, aux_addr, address_b;
   logic [DATA_W-1:0] aux_wdata, disp_rdata, aux_rdata, data_b, q_b;
   logic [3:0]        aux_byteena, byteena_b;
   logic              disp_gnt, disp_valid, aux_gnt, aux_valid, rden_b, wren_b;
   logic [15:0]       disp_miss_cnt;

   ram_port_b_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .blank(blank),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rdata(disp_rdata), .disp_valid(disp_valid), .disp_miss_cnt(disp_miss_cnt),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_byteena(aux_byteena), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_valid(aux_valid),
      .address_b(address_b), .data_b(data_b), .byteena_b(byteena_b),
      .rden_b(rden_b), .wren_b(wren_b), .q_b(q_b)
   );

   always #5 clk = ~clk;

   // RAM port B model: writes and reads are captured at the edge, data emerges RD_LAT cycles later.
   logic [31:0] mem [256];
   logic [31:0] qpipe [RD_LAT];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (wren_b && byteena_b[b]) mem[address_b[7:0]][8*b +: 8] <= data_b[8*b +: 8];
      qpipe[0] <= rden_b ? mem[address_b[7:0]] : 32'h0;
      for (int k = 1; k < RD_LAT; k++) qpipe[k] <= qpipe[k-1];
   end
   assign q_b = qpipe[RD_LAT-1];

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct { int due; bit is_aux; logic [31:0] data; } resp_t;
   resp_t       rq[$];
   logic [31:0] refmem [256];
   logic [31:0] last_d = '0, last_a = '0;
   logic [16:0] e_addr = '0;
   logic [31:0] e_data = '0;
   logic [3:0]  e_be   = '0;
   bit          e_rden = 0, e_wren = 0;
   int          m_starve = 0, m_miss = 0;
   int          cyc = 0;
   bit          mon_en = 0;
   int          dv_cnt = 0, av_cnt = 0, wr_cnt = 0;

   task automatic model_step();
      bit          exp_dv, exp_av, wd, wa;
      logic [31:0] dd, ad, w;
      resp_t       r;
      exp_dv = 0; exp_av = 0; wd = 0; wa = 0;
      dd = last_d; ad = last_a;
      if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         if (r.is_aux) begin exp_av = 1; ad = r.data; end
         else begin exp_dv = 1; dd = r.data; end
      end
      check("disp_valid", 32'(disp_valid), 32'(exp_dv));
      check("aux_valid",  32'(aux_valid),  32'(exp_av));
      check("disp_rdata", disp_rdata, dd);
      check("aux_rdata",  aux_rdata,  ad);
      check("address_b",  32'(address_b), 32'(e_addr));
      check("data_b",     data_b, e_data);
      check("byteena_b",  32'(byteena_b), 32'(e_be));
      check("rden_b",     32'(rden_b), 32'(e_rden));
      check("wren_b",     32'(wren_b), 32'(e_wren));
      check("disp_miss_cnt", 32'(disp_miss_cnt), 32'(m_miss));
      if (!rst) begin
         if (aux_req && (m_starve == LIMIT || blank)) wa = 1;
         else if (disp_req)                          wd = 1;
         else if (aux_req)                           wa = 1;
      end
      check("disp_gnt", 32'(disp_gnt), 32'(wd));
      check("aux_gnt",  32'(aux_gnt),  32'(wa));
      dv_cnt += int'(disp_valid);
      av_cnt += int'(aux_valid);
      wr_cnt += int'(wren_b);
      if (rst) begin
         rq.delete();
         last_d = '0; last_a = '0;
         e_addr = '0; e_data = '0; e_be = '0; e_rden = 0; e_wren = 0;
         m_starve = 0; m_miss = 0;
      end else begin
         last_d = dd; last_a = ad;
         m_starve = (aux_req && !wa) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
         if (disp_req && !wd && m_miss < 65535) m_miss++;
         e_rden = 0; e_wren = 0;
         if (wd) begin
            e_addr = disp_addr; e_be = 4'hF; e_rden = 1;
            rq.push_back('{cyc + 1 + RD_LAT, 1'b0, refmem[disp_addr[7:0]]});
         end else if (wa && aux_we) begin
            e_addr = aux_addr; e_data = aux_wdata; e_be = aux_byteena; e_wren = 1;
            w = refmem[aux_addr[7:0]];
            for (int b = 0; b < 4; b++) if (aux_byteena[b]) w[8*b +: 8] = aux_wdata[8*b +: 8];
            refmem[aux_addr[7:0]] = w;
         end else if (wa) begin
            e_addr = aux_addr; e_be = 4'hF; e_rden = 1;
            rq.push_back('{cyc + 1 + RD_LAT, 1'b1, refmem[aux_addr[7:0]]});
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en) model_step();
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      blank = 0; disp_req = 0; aux_req = 0; aux_we = 0;
      disp_addr = '0; aux_addr = '0; aux_wdata = '0; aux_byteena = '0;
   endtask

   typedef struct { bit b; bit d; bit a; bit eg_d; bit eg_a; } vec_t;
   vec_t tbl[8];

   // Holds disp and aux read requests until an aux grant; returns the cycle index of that grant.
   task automatic run_to_force(output int n);
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         step();
         blank = 0; disp_req = 1; disp_addr = 17'(i); aux_req = 1; aux_we = 0; aux_addr = 17'h40;
         @(negedge clk);
         if (aux_gnt) n = i;
      end
   endtask

   initial begin
      int n, g, ga, gd, d0, m0, w0;
      bit found;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
         refmem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      end
      mem[16] = '0; refmem[16] = '0;
      for (int k = 0; k < RD_LAT; k++) qpipe[k] = '0;
      idle_inputs();
      rst = 1;
      step(); step();
      mon_en = 1;
      disp_req = 1; aux_req = 1;
      @(negedge clk);
      check("gnt_in_rst_disp", 32'(disp_gnt), 32'd0);
      check("gnt_in_rst_aux",  32'(aux_gnt),  32'd0);
      check("rst_address_b",   32'(address_b), 32'd0);
      check("rst_byteena_b",   32'(byteena_b), 32'd0);
      step();
      rst = 0; idle_inputs();

      tbl[0] = '{0,0,0,0,0}; tbl[1] = '{0,1,0,1,0}; tbl[2] = '{0,0,1,0,1}; tbl[3] = '{0,1,1,1,0};
      tbl[4] = '{1,0,0,0,0}; tbl[5] = '{1,1,0,1,0}; tbl[6] = '{1,0,1,0,1}; tbl[7] = '{1,1,1,0,1};
      for (int i = 0; i < 8; i++) begin
         step();
         blank = tbl[i].b; disp_req = tbl[i].d; aux_req = tbl[i].a; aux_we = 0;
         disp_addr = 17'(i); aux_addr = 17'(i + 32);
         @(negedge clk);
         check("tbl_disp_gnt", 32'(disp_gnt), 32'(tbl[i].eg_d));
         check("tbl_aux_gnt",  32'(aux_gnt),  32'(tbl[i].eg_a));
         step();
         idle_inputs();
      end

      // Reset while a display read is in flight
      step();
      disp_req = 1; disp_addr = 17'h5;
      @(negedge clk);
      check("rmr_gnt", 32'(disp_gnt), 32'd1);
      step();
      disp_req = 0; rst = 1;
      step();
      rst = 0;
      d0 = dv_cnt;
      @(negedge clk);
      check("rmr_address_b", 32'(address_b), 32'd0);
      check("rmr_rden_b",    32'(rden_b),    32'd0);
      repeat (6) step();
      check("rmr_no_disp_valid", 32'(dv_cnt - d0), 32'd0);

      // Display stream 0x00004..0x00013
      d0 = dv_cnt; m0 = int'(disp_miss_cnt); g = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         disp_req = 1; disp_addr = 17'(4 + i);
         @(negedge clk);
         g += int'(disp_gnt);
      end
      step();
      idle_inputs();
      repeat (5) step();
      check("stream_gnts",   32'(g), 32'd16);
      check("stream_valids", 32'(dv_cnt - d0), 32'd16);
      check("stream_miss",   32'(disp_miss_cnt), 32'(m0));

      // Starvation: forced grant on the 9th cycle, then again 9 cycles later
      m0 = int'(disp_miss_cnt);
      run_to_force(n);
      check("starve_first_force", 32'(n), 32'(LIMIT + 1));
      step();
      check("starve_miss_one", 32'(disp_miss_cnt), 32'(m0 + 1));
      run_to_force(n);
      check("starve_second_force", 32'(n), 32'(LIMIT));
      step();
      idle_inputs();

      // Blanking gives aux priority every cycle
      step();
      m0 = int'(disp_miss_cnt); ga = 0; gd = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         blank = 1; disp_req = 1; disp_addr = 17'h7; aux_req = 1; aux_we = 0; aux_addr = 17'(64 + i);
         @(negedge clk);
         ga += int'(aux_gnt); gd += int'(disp_gnt);
      end
      step();
      idle_inputs();
      check("blank_aux_gnts",  32'(ga), 32'd5);
      check("blank_disp_gnts", 32'(gd), 32'd0);
      check("blank_miss",      32'(disp_miss_cnt), 32'(m0 + 5));

      // Partial write then read-back of the same word
      repeat (4) step();
      d0 = dv_cnt;
      aux_req = 1; aux_we = 1; aux_addr = 17'h10; aux_wdata = 32'hDEADBEEF; aux_byteena = 4'b0011;
      @(negedge clk);
      check("wr_gnt", 32'(aux_gnt), 32'd1);
      step();
      aux_we = 0;
      @(negedge clk);
      check("rd_gnt", 32'(aux_gnt), 32'd1);
      step();
      idle_inputs();
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (aux_valid) begin
            found = 1;
            check("wr_rd_data", aux_rdata, 32'h0000BEEF);
         end
      end
      check("wr_rd_valid_seen", 32'(found), 32'd1);
      step();
      check("wr_rd_disp_untouched", 32'(dv_cnt - d0), 32'd0);

      // Aux request dropped after 3 denied cycles
      step();
      w0 = wr_cnt; ga = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         disp_req = 1; disp_addr = 17'(90 + i);
         aux_req = 1; aux_we = 1; aux_addr = 17'h20; aux_wdata = 32'h12345678; aux_byteena = 4'hF;
         @(negedge clk);
         ga += int'(aux_gnt);
      end
      step();
      idle_inputs();
      repeat (3) step();
      check("drop_no_aux_gnt", 32'(ga), 32'd0);
      check("drop_no_write",   32'(wr_cnt - w0), 32'd0);
      run_to_force(n);
      check("drop_starve_cleared", 32'(n), 32'(LIMIT + 1));
      step();
      idle_inputs();

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         step();
         blank       = ($urandom_range(0, 3) == 0);
         disp_req    = 1'($urandom_range(0, 1));
         aux_req     = 1'($urandom_range(0, 1));
         aux_we      = 1'($urandom_range(0, 1));
         disp_addr   = 17'($urandom_range(0, 255));
         aux_addr    = 17'($urandom_range(0, 255));
         aux_wdata   = $urandom;
         aux_byteena = 4'($urandom_range(0, 15));
      end
      step();
      idle_inputs();
      repeat (8) step();
      check("resp_drain", 32'(rq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_port_b_arbiter.md
# ram_port_b_arbiter

Arbitrates the single read/write port B of the shared image RAM between two requesters. The display requester is the VGA pixel fetch path, and the auxiliary requester is the processor or loader side. Display fetches have priority during active video; auxiliary traffic gets priority during blanking and cannot starve indefinitely. The block drives the RAM port B pins directly and returns tagged read data to whichever requester issued each read.

## Interface
Parameters:
- ADDR_W, 17, RAM word-address width.
- DATA_W, 32, RAM data width.
- RD_LATENCY, 2, cycles from registered address_b to valid q_b (legal range 1–4).
- STARVE_LIMIT, 8, consecutive denied auxiliary-request cycles before a forced auxiliary grant (legal range 1–255).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset: synchronous, active-high.
- blank  in  1  1 = VGA blanking interval.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  combinational; display request accepted this cycle.
- disp_rdata  out  DATA_W  display read data.
- disp_valid  out  1  disp_rdata valid; one pulse per granted display read.
- disp_miss_cnt  out  16  saturating count of denied display-request cycles.
- aux_req  in  1  auxiliary request.
- aux_we  in  1  1 = write, 0 = read.
- aux_addr  in  ADDR_W  auxiliary address.
- aux_wdata  in  DATA_W  auxiliary write data.
- aux_byteena  in  4  auxiliary write byte enables.
- aux_gnt  out  1  combinational; auxiliary request accepted this cycle.
- aux_rdata  out  DATA_W  auxiliary read data.
- aux_valid  out  1  aux_rdata valid; one pulse per granted auxiliary read.
- address_b  out  ADDR_W  RAM port B address (registered).
- data_b  out  DATA_W  RAM port B write data (registered).
- byteena_b  out  4  RAM port B byte enables (registered).
- rden_b  out  1  RAM port B read enable (registered).
- wren_b  out  1  RAM port B write enable (registered).
- q_b  in  DATA_W  RAM port B read data.

## Operation
- Arbitration is evaluated every cycle. Priority, highest first:
  - FORCE_AUX: aux_req && starve_cnt == STARVE_LIMIT.
  - BLANK_AUX: blank && aux_req.
  - DISP: disp_req.
  - AUX: aux_req.
  - IDLE.
- Exactly one of disp_gnt or aux_gnt is high in a non-idle cycle. Neither is high when IDLE.
- Owner state register (IDLE / DISP / AUX) records the winner and is used for debug and tag generation.
- Display grant: address_b <= disp_addr; rden_b <= 1; wren_b <= 0; byteena_b <= 4'b1111.
- Auxiliary read grant: address_b <= aux_addr; rden_b <= 1; wren_b <= 0; byteena_b <= 4'b1111.
- Auxiliary write grant: address_b <= aux_addr; data_b <= aux_wdata; byteena_b <= aux_byteena; wren_b <= 1; rden_b <= 0.
- IDLE cycle: rden_b <= 0 and wren_b <= 0. address_b, data_b and byteena_b hold their previous values.
- Tag pipeline: a shift register of depth RD_LATENCY+1 carries {valid, owner} for every read.
  - At the tail, q_b is routed to disp_rdata or aux_rdata and the matching valid is pulsed.
  - Writes insert valid = 0.
  - Read data outputs hold their value between valid pulses.
- starve_cnt (8 bit):
  - Increments each cycle aux_req = 1 && aux_gnt = 0, saturating at STARVE_LIMIT.
  - Clears on aux_gnt or when aux_req = 0.
- disp_miss_cnt increments each cycle disp_req = 1 && disp_gnt = 0, saturating at 16'hFFFF. It clears only on rst.
- Requester contract: a requester holds its req, addr, data and we stable until it sees its gnt. Deasserting req before gnt is legal and drops the request.

## Timing
- On rst:
  - address_b = 0, data_b = 0, byteena_b = 4'b0000, rden_b = 0, wren_b = 0.
  - disp_valid = 0, aux_valid = 0, disp_rdata = 0, aux_rdata = 0.
  - disp_miss_cnt = 0, starve_cnt = 0, owner = IDLE.
  - Tag pipeline fully invalidated: reads in flight when rst asserts never produce a valid.
- gnt outputs are zero while rst = 1.
- Grant in cycle N means the RAM pins are driven in cycle N+1. Read data valid appears at N+1+RD_LATENCY. With the default RD_LATENCY = 2, that is N+3.
- Back-to-back grants are allowed every cycle, giving one access per cycle throughput. Responses return in grant order.
- Simultaneous disp_req, aux_req and blank = 0 with starve_cnt < STARVE_LIMIT: display wins and starve_cnt increments.
- A forced auxiliary grant costs the display exactly one slot: disp_miss_cnt increments by 1 and starve_cnt returns to 0.
- The auxiliary write result is visible to a following read of the same address on port B granted in N+1 or later.

## Test plan
- Reset mid-read: grant a display read at N, assert rst at N+1 → no disp_valid ever; all outputs at their reset values the cycle after rst.
- Display stream: disp_req held, addresses 0x00004..0x00013, blank = 0, no aux → 16 disp_gnt, 16 disp_valid pulses each RD_LATENCY+1 after its grant, data in order, disp_miss_cnt = 0.
- Starvation: disp_req and aux_req both held, blank = 0, STARVE_LIMIT = 8 → aux_gnt on the 9th cycle of aux_req. disp_miss_cnt = 1 and starve_cnt = 0 afterwards.
- Blanking priority: blank = 1 with both requesting → aux_gnt every cycle and disp_gnt = 0. disp_miss_cnt counts each of those cycles.
- Write then read: aux write 0xDEADBEEF with byteena 4'b0011 to 0x00010 (prior contents 0), then aux read 0x00010 → aux_valid with aux_rdata = 0x0000BEEF and disp_valid untouched.
- Drop request: aux_req high for 3 denied cycles then low → starve_cnt returns to 0, no aux_gnt, no RAM write.
